// File: rtl/pipe_adder_pkg.sv
// Shared opcodes and sizing helpers for the pipelined add/sub unit.
// The slice helpers keep the width split consistent across files.
package pipe_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int slice_w(input int w, input int s);
    return w / s;
  endfunction

  function automatic bit slice_ok(input int w, input int s);
    return (s >= 1) && (w % s == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// Combinational ripple of full-adder cells for one operand slice.
// ct is the carry into the top bit, used for signed overflow.
module add_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         ct
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign s  = a ^ b ^ c[W-1:0];
  assign co = c[W];
  assign ct = c[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/sub: one SLICE-bit carry chain resolved per stage,
// operands skewed in and sum slices deskewed so results exit whole.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SLICE = slice_w(WIDTH, STAGES);

  if (!slice_ok(WIDTH, STAGES)) begin : g_chk
    $error("pipe_adder: WIDTH must be a multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             cx;

  logic             v  [STAGES];
  logic             c  [STAGES];
  logic             o  [STAGES];
  logic [WIDTH-1:0] s  [STAGES];
  logic [WIDTH-1:0] ra [STAGES];
  logic [WIDTH-1:0] rb [STAGES];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign bx       = (in_sub == OP_SUB) ? ~in_b : in_b;
  assign cx       = (in_sub == OP_SUB) ? 1'b1 : in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
    logic [WIDTH-1:0] ps;
    logic [WIDTH-1:0] ns;
    logic             pc;
    logic             pv;
    logic [SLICE-1:0] ys;
    logic             yc;
    logic             yt;

    if (k == 0) begin : g_head
      assign pa = in_a;
      assign pb = bx;
      assign pc = cx;
      assign pv = in_valid;
      assign ps = '0;
    end else begin : g_body
      assign pa = ra[k-1];
      assign pb = rb[k-1];
      assign pc = c[k-1];
      assign pv = v[k-1];
      assign ps = s[k-1];
    end

    add_slice #(.W(SLICE)) u_slice (
      .a  (pa[SLICE-1:0]),
      .b  (pb[SLICE-1:0]),
      .ci (pc),
      .s  (ys),
      .co (yc),
      .ct (yt)
    );

    // New slice enters at the top; earlier slices shift toward the LSB.
    assign ns = (ps >> SLICE)
              | (WIDTH'(ys) << (WIDTH - SLICE));

    always_ff @(posedge clk) begin
      if (rst) begin
        v[k]  <= 1'b0;
        c[k]  <= 1'b0;
        o[k]  <= 1'b0;
        s[k]  <= '0;
        ra[k] <= '0;
        rb[k] <= '0;
      end else if (adv) begin
        v[k] <= pv;
        if (pv) begin
          c[k]  <= yc;
          o[k]  <= yc ^ yt;
          s[k]  <= ns;
          ra[k] <= pa >> SLICE;
          rb[k] <= pb >> SLICE;
        end
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_sum   = s[STAGES-1];
  assign out_cout  = c[STAGES-1];
  assign out_ovf   = o[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder at WIDTH=16, STAGES=4.
// Expected results are hand-computed constants in the vector table.
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_sub;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int ncmp = 0;
  int nbad = 0;

  logic [15:0] ta [10];
  logic [15:0] tb [10];
  logic        tsub [10];
  logic        tcin [10];
  logic [15:0] es [10];
  logic        ec [10];
  logic        eo [10];

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic vld, input int i);
    in_valid = vld;
    in_a     = ta[i];
    in_b     = tb[i];
    in_sub   = tsub[i];
    in_cin   = tcin[i];
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int i);
    chk({tag, "_v"}, 32'(out_valid), 32'(1'b1));
    chk({tag, "_sum"}, 32'(out_sum), 32'(es[i]));
    chk({tag, "_cout"}, 32'(out_cout), 32'(ec[i]));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo[i]));
  endtask

  initial begin
    ta[0]=16'hFFFF; tb[0]=16'h0001; tsub[0]=0; tcin[0]=0;
    es[0]=16'h0000; ec[0]=1; eo[0]=0;
    ta[1]=16'h7FFF; tb[1]=16'h0001; tsub[1]=0; tcin[1]=0;
    es[1]=16'h8000; ec[1]=0; eo[1]=1;
    ta[2]=16'h0003; tb[2]=16'h0005; tsub[2]=1; tcin[2]=0;
    es[2]=16'hFFFE; ec[2]=0; eo[2]=0;
    ta[3]=16'h8000; tb[3]=16'h0001; tsub[3]=1; tcin[3]=1;
    es[3]=16'h7FFF; ec[3]=1; eo[3]=1;
    ta[4]=16'h1234; tb[4]=16'h1111; tsub[4]=0; tcin[4]=1;
    es[4]=16'h2346; ec[4]=0; eo[4]=0;
    ta[5]=16'h0005; tb[5]=16'h0005; tsub[5]=1; tcin[5]=0;
    es[5]=16'h0000; ec[5]=1; eo[5]=0;
    ta[6]=16'h8000; tb[6]=16'h8000; tsub[6]=0; tcin[6]=0;
    es[6]=16'h0000; ec[6]=1; eo[6]=1;
    ta[7]=16'h0000; tb[7]=16'h0001; tsub[7]=1; tcin[7]=0;
    es[7]=16'hFFFF; ec[7]=0; eo[7]=0;
    ta[8]=16'h0F0F; tb[8]=16'h0101; tsub[8]=0; tcin[8]=0;
    es[8]=16'h1010; ec[8]=0; eo[8]=0;
    ta[9]=16'h00FF; tb[9]=16'h0001; tsub[9]=0; tcin[9]=0;
    es[9]=16'h0100; ec[9]=0; eo[9]=0;

    rst = 1'b1;
    out_ready = 1'b1;
    put(1'b0, 0);
    step();
    step();
    rst = 1'b0;
    chk("rst_v", 32'(out_valid), 32'(1'b0));
    chk("rst_sum", 32'(out_sum), 32'h0);
    chk("rst_cout", 32'(out_cout), 32'(1'b0));
    chk("rst_ovf", 32'(out_ovf), 32'(1'b0));
    chk("rst_rdy", 32'(in_ready), 32'(1'b1));
    step();
    chk("idle_v", 32'(out_valid), 32'(1'b0));

    // single add, carry crosses a slice boundary
    put(1'b1, 9);
    step();
    put(1'b0, 0);
    step();
    step();
    chk("lat3_v", 32'(out_valid), 32'(1'b0));
    step();
    chk_out("single", 9);
    step();
    chk("single_end", 32'(out_valid), 32'(1'b0));

    // 8-beat back-to-back stream
    for (int n = 0; n < 11; n++) begin
      if (n < 8) put(1'b1, n);
      else put(1'b0, 0);
      step();
      if (n >= 3) chk_out("stream", n - 3);
    end
    step();
    chk("stream_end", 32'(out_valid), 32'(1'b0));

    // backpressure with a full pipe
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      put(1'b1, n);
      step();
    end
    put(1'b1, 4);
    for (int n = 0; n < 5; n++) begin
      chk("bp_rdy", 32'(in_ready), 32'(1'b0));
      chk_out("bp_hold", 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(in_ready), 32'(1'b1));
    step();
    put(1'b0, 0);
    chk_out("bp_1", 1);
    step();
    chk_out("bp_2", 2);
    step();
    chk_out("bp_3", 3);
    step();
    chk_out("bp_4", 4);
    step();
    chk("bp_end", 32'(out_valid), 32'(1'b0));

    // bubbles: 1,0,1,0 in, same pattern out
    for (int n = 0; n < 8; n++) begin
      if (n < 4 && n % 2 == 0) put(1'b1, 5 + n / 2);
      else put(1'b0, 0);
      step();
      if (n >= 3) begin
        chk("bub_v", 32'(out_valid),
            32'((n - 3) < 4 && (n - 3) % 2 == 0));
      end
      if (n == 3) chk_out("bub_a", 5);
      if (n == 5) chk_out("bub_b", 6);
    end

    // reset with 3 beats in flight
    for (int n = 0; n < 3; n++) begin
      put(1'b1, n);
      step();
    end
    put(1'b0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_v", 32'(out_valid), 32'(1'b0));
    chk("mrst_sum", 32'(out_sum), 32'h0);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("mrst_idle", 32'(out_valid), 32'(1'b0));
    end
    put(1'b1, 8);
    step();
    put(1'b0, 0);
    step();
    step();
    chk("mrst_lat3", 32'(out_valid), 32'(1'b0));
    step();
    chk_out("mrst_new", 8);
    step();
    chk("mrst_end", 32'(out_valid), 32'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
